// File: rtl/mlp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mlp_pkg: shared widths and types for the MLP activation collector  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mlp_pkg;

  localparam int ACC_W   = 16;
  localparam int ACT_W   = 4;
  localparam int ACT_MAX = (1 << (ACT_W - 1)) - 1;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [ACT_W-1:0] act_t;

endpackage : mlp_pkg
`default_nettype wire

// File: rtl/mlp_act_quant.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mlp_act_quant: ReLU word -> signed activation (shift + saturate)   |
// | Optional round-half-up before the shift: MLP_ACT_ROUND_EN          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mlp_act_quant
  import mlp_pkg::*;
#(
  parameter int SHIFT_W = 4
) (
  input  acc_t               acc_in,
  input  logic [SHIFT_W-1:0] shift,
  output act_t               q
);

  // One extra bit of headroom so the rounding bias can never wrap.
  logic [ACC_W:0] w_mag;
  logic [ACC_W:0] w_sum;
  logic [ACC_W:0] w_shr;

  assign w_mag = {1'b0, acc_in};

`ifdef MLP_ACT_ROUND_EN
  logic [ACC_W:0] w_bias;

  always_comb begin
    w_bias = '0;
    if (shift != '0) begin
      w_bias = (ACC_W+1)'(1) << (shift - SHIFT_W'(1));
    end
  end

  assign w_sum = w_mag + w_bias;
`else
  assign w_sum = w_mag;
`endif

  assign w_shr = w_sum >> shift;

  always_comb begin
    q = '0;
    if (acc_in[ACC_W-1]) begin
      q = '0;
    end else if (w_shr > (ACC_W+1)'(ACT_MAX)) begin
      q = act_t'(ACT_MAX);
    end else begin
      q = act_t'(w_shr[ACT_W-1:0]);
    end
  end

endmodule : mlp_act_quant
`default_nettype wire

// File: rtl/mlp_act_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mlp_act_collector: requantize finished dot products into a FIFO    |
// | feeding the next layer; rounding option via MLP_ACT_ROUND_EN       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mlp_act_collector
  import mlp_pkg::act_t;
#(
  parameter int ACC_W   = 16,
  parameter int ACT_W   = 4,
  parameter int DEPTH   = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic signed [ACC_W-1:0]  acc_in,
  input  logic                     acc_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACT_W-1:0]  out_act,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic signed [ACT_W-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]      r_wr_ptr;
  logic [c_ptr_w-1:0]      r_rd_ptr;
  logic [c_ptr_w:0]        r_count;
  logic                    r_overflow;

  act_t w_q;
  logic w_pop;
  logic w_push;
  logic w_drop;

  mlp_act_quant #(
    .SHIFT_W (SHIFT_W)
  ) u_quant (
    .acc_in (acc_in),
    .shift  (shift),
    .q      (w_q)
  );

  assign out_valid = (r_count != '0);
  assign full      = (r_count == (c_ptr_w+1)'(DEPTH));
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign out_act   = out_valid ? r_mem[r_rd_ptr] : '0;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_pop  = out_valid & out_ready;
  assign w_push = acc_valid & (~full | w_pop);
  assign w_drop = acc_valid & full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && w_push) begin
      r_mem[r_wr_ptr] <= w_q;
    end
  end

endmodule : mlp_act_collector
`default_nettype wire

// File: tb/tb_mlp_act_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mlp_act_collector: vector table + scoreboard bench              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mlp_act_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        acc_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  shift = '0;
  logic [15:0] acc_in = '0;
  logic        out_valid;
  logic        full;
  logic        overflow;
  logic [3:0]  out_act;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] sb [$];
  logic [3:0] mon_exp;

  typedef struct {
    logic [3:0]  shift;
    logic [15:0] acc;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs [13];

  mlp_act_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .shift     (shift),
    .acc_in    (acc_in),
    .acc_valid (acc_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_act   (out_act),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [15:0] a,
                      input logic [3:0] e, input bit queue_it);
    shift     = s;
    acc_in    = a;
    acc_valid = 1'b1;
    if (queue_it) sb.push_back(e);
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && count != 0; i++) tick();
    check("drain_empty", int'(count), 0);
    check("drain_sb_empty", sb.size(), 0);
  endtask

  // Pops are observed on the falling edge, before the edge that retires them.
  always @(negedge clk) begin
    if (rst_n && !clr && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %0d expected none", out_act);
      end else begin
        mon_exp = sb.pop_front();
        check("pop_data", int'(out_act), int'(mon_exp));
      end
    end
  end

  initial begin
    vecs[0]  = '{4'd4,  16'h0050, 4'd5};
`ifdef MLP_ACT_ROUND_EN
    vecs[1]  = '{4'd4,  16'h0058, 4'd6};
    vecs[7]  = '{4'd15, 16'h7FFF, 4'd1};
    vecs[9]  = '{4'd1,  16'h000D, 4'd7};
`else
    vecs[1]  = '{4'd4,  16'h0058, 4'd5};
    vecs[7]  = '{4'd15, 16'h7FFF, 4'd0};
    vecs[9]  = '{4'd1,  16'h000D, 4'd6};
`endif
    vecs[2]  = '{4'd0,  16'h0003, 4'd3};
    vecs[3]  = '{4'd4,  16'h0200, 4'd7};
    vecs[4]  = '{4'd4,  16'hFF00, 4'd0};
    vecs[5]  = '{4'd0,  16'h0007, 4'd7};
    vecs[6]  = '{4'd0,  16'h0008, 4'd7};
    vecs[8]  = '{4'd3,  16'h003F, 4'd7};
    vecs[10] = '{4'd2,  16'h7FFF, 4'd7};
    vecs[11] = '{4'd0,  16'h0000, 4'd0};
    vecs[12] = '{4'd4,  16'h8000, 4'd0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_act", int'(out_act), 0);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Single-shot quantization vectors: one cycle latency, gone after the pop.
    for (int i = 0; i < 13; i++) begin
      push(vecs[i].shift, vecs[i].acc, vecs[i].exp, 1'b1);
      check("lat_out_valid", int'(out_valid), 1);
      tick();
      check("after_pop_count", int'(count), 0);
    end

    // Fill to DEPTH with no consumer.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push(4'd0, 16'(i), (i > 7) ? 4'd7 : 4'(i), 1'b1);
    end
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 8);
    check("fill_overflow", int'(overflow), 0);

    // Full with simultaneous push and pop.
    out_ready = 1'b1;
    push(4'd0, 16'h0005, 4'd5, 1'b1);
    out_ready = 1'b0;
    check("pushpop_count", int'(count), 8);
    check("pushpop_overflow", int'(overflow), 0);

    // Blocked push.
    push(4'd0, 16'h0003, 4'd3, 1'b0);
    check("drop_overflow", int'(overflow), 1);
    check("drop_count", int'(count), 8);

    drain();
    check("sticky_overflow", int'(overflow), 1);
    check("drained_out_valid", int'(out_valid), 0);
    check("drained_out_act", int'(out_act), 0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_overflow", int'(overflow), 0);

    // Asynchronous reset in the middle of a drain.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(4'd0, 16'(i), 4'(i), 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("mid_count", int'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_count", int'(count), 0);
    check("arst_out_act", int'(out_act), 0);
    rst_n = 1'b1;
    sb.delete();
    tick();

    // acc_valid held across clock edges while in reset.
    rst_n = 1'b0;
    acc_valid = 1'b1;
    acc_in = 16'h0001;
    shift = 4'd0;
    tick();
    tick();
    acc_valid = 1'b0;
    rst_n = 1'b1;
    check("rst_ignore_count", int'(count), 0);

    // clr wins over a same-cycle push.
    push(4'd0, 16'h0002, 4'd2, 1'b1);
    push(4'd0, 16'h0006, 4'd6, 1'b1);
    check("pre_clr_count", int'(count), 2);
    clr = 1'b1;
    acc_valid = 1'b1;
    acc_in = 16'h0004;
    tick();
    clr = 1'b0;
    acc_valid = 1'b0;
    check("clr_push_count", int'(count), 0);
    check("clr_push_out_valid", int'(out_valid), 0);
    sb.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mlp_act_collector
`default_nettype wire
